// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one single-port synchronous memory between
// instruction fetch (IF) and the data-memory stage (DM), with a fetch starvation guard.
module mem_arbiter #(
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned WORD       = 32,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_gnt_o,
   output logic              if_rvalid_o,
   output logic [WORD-1:0]   if_rdata_o,

   input  logic              dm_req_i,
   input  logic              dm_we_i,
   input  logic [ADDR_W-1:0] dm_addr_i,
   input  logic [WORD-1:0]   dm_wdata_i,
   output logic              dm_gnt_o,
   output logic              dm_rvalid_o,
   output logic [WORD-1:0]   dm_rdata_o,

   output logic [ADDR_W-1:0] mem_a_o,
   output logic              mem_w_o,
   output logic [WORD-1:0]   mem_d_o,
   input  logic [WORD-1:0]   mem_q_i
);

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_e;

   localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);

   logic [3:0]        r_starve_cnt;
   owner_e            r_rd_owner;
   logic              r_rd_pend;
   logic [ADDR_W-1:0] r_last_addr;

   logic              w_if_gnt;
   logic              w_dm_gnt;
   logic              w_granted;
   logic              w_wr;

   // Grants are forced low while reset is asserted so the port is idle immediately.
   always_comb begin
      w_if_gnt = 1'b0;
      w_dm_gnt = 1'b0;
      if (rst) begin
         if (if_req_i && dm_req_i) begin
            if (r_starve_cnt >= C_STARVE_MAX) begin
               w_if_gnt = 1'b1;
            end else begin
               w_dm_gnt = 1'b1;
            end
         end else begin
            w_if_gnt = if_req_i;
            w_dm_gnt = dm_req_i;
         end
      end
   end

   assign w_granted = w_if_gnt | w_dm_gnt;
   assign w_wr      = w_dm_gnt & dm_we_i;

   assign if_gnt_o  = w_if_gnt;
   assign dm_gnt_o  = w_dm_gnt;

   // With no grant the address bus parks on the last issued address.
   always_comb begin
      mem_a_o = r_last_addr;
      if (w_if_gnt) begin
         mem_a_o = if_addr_i;
      end else if (w_dm_gnt) begin
         mem_a_o = dm_addr_i;
      end
   end

   assign mem_w_o = w_wr;
   assign mem_d_o = rst ? dm_wdata_i : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_starve_cnt <= '0;
         r_rd_owner   <= OWN_IF;
         r_rd_pend    <= 1'b0;
         r_last_addr  <= '0;
      end else begin
         if (w_granted) begin
            r_last_addr <= mem_a_o;
            r_rd_owner  <= w_if_gnt ? OWN_IF : OWN_DM;
         end
         r_rd_pend <= w_granted & ~w_wr;

         // A fresh IF request does not clear a saturated count; only an IF win does.
         if (!if_req_i || w_if_gnt) begin
            r_starve_cnt <= '0;
         end else if (w_dm_gnt && (r_starve_cnt < C_STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
         end
      end
   end

   assign if_rvalid_o = r_rd_pend & (r_rd_owner == OWN_IF);
   assign dm_rvalid_o = r_rd_pend & (r_rd_owner == OWN_DM);
   assign if_rdata_o  = mem_q_i;
   assign dm_rdata_o  = mem_q_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and constrained-random bench for mem_arbiter with a behavioural SRAM.
module tb_mem_arbiter;

   localparam int unsigned ADDR_W     = 16;
   localparam int unsigned WORD       = 32;
   localparam int unsigned STARVE_MAX = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              if_req_i;
   logic [ADDR_W-1:0] if_addr_i;
   logic              if_gnt_o;
   logic              if_rvalid_o;
   logic [WORD-1:0]   if_rdata_o;
   logic              dm_req_i;
   logic              dm_we_i;
   logic [ADDR_W-1:0] dm_addr_i;
   logic [WORD-1:0]   dm_wdata_i;
   logic              dm_gnt_o;
   logic              dm_rvalid_o;
   logic [WORD-1:0]   dm_rdata_o;
   logic [ADDR_W-1:0] mem_a_o;
   logic              mem_w_o;
   logic [WORD-1:0]   mem_d_o;
   logic [WORD-1:0]   mem_q_i;

   int errors = 0;
   int checks = 0;

   mem_arbiter #(
      .ADDR_W    (ADDR_W),
      .WORD      (WORD),
      .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .if_req_i   (if_req_i),
      .if_addr_i  (if_addr_i),
      .if_gnt_o   (if_gnt_o),
      .if_rvalid_o(if_rvalid_o),
      .if_rdata_o (if_rdata_o),
      .dm_req_i   (dm_req_i),
      .dm_we_i    (dm_we_i),
      .dm_addr_i  (dm_addr_i),
      .dm_wdata_i (dm_wdata_i),
      .dm_gnt_o   (dm_gnt_o),
      .dm_rvalid_o(dm_rvalid_o),
      .dm_rdata_o (dm_rdata_o),
      .mem_a_o    (mem_a_o),
      .mem_w_o    (mem_w_o),
      .mem_d_o    (mem_d_o),
      .mem_q_i    (mem_q_i)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_val(input logic [15:0] a);
      case (a)
         16'h0010: init_val = 32'hDEADBEEF;
         16'h0020: init_val = 32'hA5A50020;
         16'h0030: init_val = 32'h3C3C0030;
         default:  init_val = {a ^ 16'h5A5A, a};
      endcase
   endfunction

   // Behavioural single-port SRAM: unwritten words read their init value.
   logic [31:0] sram    [0:65535];
   bit          sram_wr [0:65535];
   always @(posedge clk) begin
      if (mem_w_o) begin
         sram[mem_a_o]    <= mem_d_o;
         sram_wr[mem_a_o] <= 1'b1;
      end
      mem_q_i <= sram_wr[mem_a_o] ? sram[mem_a_o] : init_val(mem_a_o);
   end

   // Independent reference contents, updated from the bench's own predictions.
   logic [31:0] ref_mem [0:65535];
   bit          ref_wr  [0:65535];

   function automatic logic [31:0] ref_read(input logic [15:0] a);
      ref_read = ref_wr[a] ? ref_mem[a] : init_val(a);
   endfunction

   task automatic drive_idle;
      if_req_i   = 1'b0;
      if_addr_i  = '0;
      dm_req_i   = 1'b0;
      dm_we_i    = 1'b0;
      dm_addr_i  = '0;
      dm_wdata_i = '0;
   endtask

   task automatic test_reset;
      rst        = 1'b0;
      if_req_i   = 1'b1;
      if_addr_i  = 16'h1234;
      dm_req_i   = 1'b1;
      dm_we_i    = 1'b1;
      dm_addr_i  = 16'h4321;
      dm_wdata_i = 32'hCAFEF00D;
      #2;
      checks++; if (if_gnt_o !== 1'b0) begin errors++; $display("FAIL reset_if_gnt: got %b want 0", if_gnt_o); end
      checks++; if (dm_gnt_o !== 1'b0) begin errors++; $display("FAIL reset_dm_gnt: got %b want 0", dm_gnt_o); end
      checks++; if (mem_w_o !== 1'b0) begin errors++; $display("FAIL reset_mem_w: got %b want 0", mem_w_o); end
      checks++; if (mem_a_o !== 16'h0000) begin errors++; $display("FAIL reset_mem_a: got %h want 0000", mem_a_o); end
      checks++; if (mem_d_o !== 32'h0) begin errors++; $display("FAIL reset_mem_d: got %h want 0", mem_d_o); end
      checks++; if (if_rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_if_rvalid: got %b want 0", if_rvalid_o); end
      checks++; if (dm_rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_dm_rvalid: got %b want 0", dm_rvalid_o); end
      @(negedge clk);
      @(negedge clk);
      drive_idle();
      rst = 1'b1;
   endtask

   task automatic test_if_read;
      @(negedge clk);
      if_req_i  = 1'b1;
      if_addr_i = 16'h0010;
      #2;
      checks++; if (if_gnt_o !== 1'b1) begin errors++; $display("FAIL ifrd_gnt: got %b want 1", if_gnt_o); end
      checks++; if (dm_gnt_o !== 1'b0) begin errors++; $display("FAIL ifrd_dm_gnt: got %b want 0", dm_gnt_o); end
      checks++; if (mem_a_o !== 16'h0010) begin errors++; $display("FAIL ifrd_mem_a: got %h want 0010", mem_a_o); end
      checks++; if (mem_w_o !== 1'b0) begin errors++; $display("FAIL ifrd_mem_w: got %b want 0", mem_w_o); end
      @(negedge clk);
      if_req_i = 1'b0;
      #2;
      checks++; if (if_rvalid_o !== 1'b1) begin errors++; $display("FAIL ifrd_rvalid: got %b want 1", if_rvalid_o); end
      checks++; if (if_rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL ifrd_rdata: got %h want deadbeef", if_rdata_o); end
      checks++; if (dm_rvalid_o !== 1'b0) begin errors++; $display("FAIL ifrd_dm_rvalid: got %b want 0", dm_rvalid_o); end
      checks++; if (mem_a_o !== 16'h0010) begin errors++; $display("FAIL ifrd_park_addr: got %h want 0010", mem_a_o); end
   endtask

   task automatic test_starvation;
      logic exp_if, prev_valid, prev_if;
      prev_valid = 1'b0;
      prev_if    = 1'b0;
      for (int k = 0; k < 11; k++) begin
         @(negedge clk);
         if_req_i  = (k < 10);
         if_addr_i = 16'h0030;
         dm_req_i  = (k < 10);
         dm_we_i   = 1'b0;
         dm_addr_i = 16'h0020;
         #2;
         exp_if = ((k % 5) == 4);
         if (k < 10) begin
            checks++; if (if_gnt_o !== exp_if) begin errors++; $display("FAIL starve_if_gnt[%0d]: got %b want %b", k, if_gnt_o, exp_if); end
            checks++; if (dm_gnt_o !== !exp_if) begin errors++; $display("FAIL starve_dm_gnt[%0d]: got %b want %b", k, dm_gnt_o, !exp_if); end
         end
         checks++; if (if_rvalid_o !== (prev_valid & prev_if)) begin errors++; $display("FAIL starve_if_rvalid[%0d]: got %b want %b", k, if_rvalid_o, prev_valid & prev_if); end
         checks++; if (dm_rvalid_o !== (prev_valid & !prev_if)) begin errors++; $display("FAIL starve_dm_rvalid[%0d]: got %b want %b", k, dm_rvalid_o, prev_valid & !prev_if); end
         if (prev_valid) begin
            checks++;
            if (mem_q_i !== (prev_if ? 32'h3C3C0030 : 32'hA5A50020) || if_rdata_o !== dm_rdata_o)
               begin errors++; $display("FAIL starve_rdata[%0d]: got %h want %h", k, prev_if ? if_rdata_o : dm_rdata_o, prev_if ? 32'h3C3C0030 : 32'hA5A50020); end
         end
         prev_valid = (k < 10);
         prev_if    = exp_if;
      end
      drive_idle();
   endtask

   task automatic test_write_read;
      @(negedge clk);
      dm_req_i   = 1'b1;
      dm_we_i    = 1'b1;
      dm_addr_i  = 16'h0100;
      dm_wdata_i = 32'h12345678;
      #2;
      checks++; if (dm_gnt_o !== 1'b1) begin errors++; $display("FAIL wr_gnt: got %b want 1", dm_gnt_o); end
      checks++; if (mem_w_o !== 1'b1) begin errors++; $display("FAIL wr_mem_w: got %b want 1", mem_w_o); end
      checks++; if (mem_a_o !== 16'h0100) begin errors++; $display("FAIL wr_mem_a: got %h want 0100", mem_a_o); end
      checks++; if (mem_d_o !== 32'h12345678) begin errors++; $display("FAIL wr_mem_d: got %h want 12345678", mem_d_o); end
      ref_mem[16'h0100] = 32'h12345678;
      ref_wr[16'h0100]  = 1'b1;
      @(negedge clk);
      dm_we_i    = 1'b0;
      dm_wdata_i = 32'hFFFFFFFF;
      #2;
      checks++; if (dm_gnt_o !== 1'b1) begin errors++; $display("FAIL rd_gnt: got %b want 1", dm_gnt_o); end
      checks++; if (mem_w_o !== 1'b0) begin errors++; $display("FAIL rd_mem_w: got %b want 0", mem_w_o); end
      checks++; if (dm_rvalid_o !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid: got %b want 0", dm_rvalid_o); end
      @(negedge clk);
      drive_idle();
      #2;
      checks++; if (dm_rvalid_o !== 1'b1) begin errors++; $display("FAIL wr_rd_rvalid: got %b want 1", dm_rvalid_o); end
      checks++; if (dm_rdata_o !== 32'h12345678) begin errors++; $display("FAIL wr_rd_rdata: got %h want 12345678", dm_rdata_o); end
      checks++; if (if_rvalid_o !== 1'b0) begin errors++; $display("FAIL wr_rd_if_rvalid: got %b want 0", if_rvalid_o); end
   endtask

   task automatic test_withdraw;
      logic [8:0] v_ifreq, v_dmreq, v_ifg, v_dmg, v_ifv, v_dmv;
      v_ifreq = 9'b011111011;
      v_dmreq = 9'b011111111;
      v_ifg   = 9'b010000000;
      v_dmg   = 9'b001111111;
      v_ifv   = 9'b100000000;
      v_dmv   = 9'b011111110;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         if_req_i  = v_ifreq[c];
         if_addr_i = 16'h0050;
         dm_req_i  = v_dmreq[c];
         dm_we_i   = 1'b0;
         dm_addr_i = 16'h0040;
         #2;
         checks++; if (if_gnt_o !== v_ifg[c]) begin errors++; $display("FAIL wd_if_gnt[%0d]: got %b want %b", c, if_gnt_o, v_ifg[c]); end
         checks++; if (dm_gnt_o !== v_dmg[c]) begin errors++; $display("FAIL wd_dm_gnt[%0d]: got %b want %b", c, dm_gnt_o, v_dmg[c]); end
         checks++; if (if_rvalid_o !== v_ifv[c]) begin errors++; $display("FAIL wd_if_rvalid[%0d]: got %b want %b", c, if_rvalid_o, v_ifv[c]); end
         checks++; if (dm_rvalid_o !== v_dmv[c]) begin errors++; $display("FAIL wd_dm_rvalid[%0d]: got %b want %b", c, dm_rvalid_o, v_dmv[c]); end
      end
      drive_idle();
   endtask

   task automatic test_reset_outstanding;
      @(negedge clk);
      dm_req_i  = 1'b1;
      dm_we_i   = 1'b0;
      dm_addr_i = 16'h0020;
      #2;
      checks++; if (dm_gnt_o !== 1'b1) begin errors++; $display("FAIL rso_gnt: got %b want 1", dm_gnt_o); end
      @(negedge clk);
      rst        = 1'b0;
      if_req_i   = 1'b1;
      dm_we_i    = 1'b1;
      dm_wdata_i = 32'h55AA55AA;
      #2;
      checks++; if (dm_rvalid_o !== 1'b0) begin errors++; $display("FAIL rso_dm_rvalid_in_rst: got %b want 0", dm_rvalid_o); end
      checks++; if ({if_gnt_o, dm_gnt_o, mem_w_o, if_rvalid_o} !== 4'b0000) begin errors++; $display("FAIL rso_ctrl_in_rst: got %b want 0000", {if_gnt_o, dm_gnt_o, mem_w_o, if_rvalid_o}); end
      checks++; if ({mem_a_o, mem_d_o} !== 48'h0) begin errors++; $display("FAIL rso_bus_in_rst: got %h want 0", {mem_a_o, mem_d_o}); end
      @(negedge clk);
      drive_idle();
      #2;
      checks++; if (dm_rvalid_o !== 1'b0) begin errors++; $display("FAIL rso_dm_rvalid_rst2: got %b want 0", dm_rvalid_o); end
      @(negedge clk);
      rst       = 1'b1;
      if_req_i  = 1'b1;
      if_addr_i = 16'h0010;
      #2;
      checks++; if (if_gnt_o !== 1'b1) begin errors++; $display("FAIL rso_first_gnt: got %b want 1", if_gnt_o); end
      checks++; if (dm_rvalid_o !== 1'b0) begin errors++; $display("FAIL rso_dm_rvalid_after: got %b want 0", dm_rvalid_o); end
      @(negedge clk);
      drive_idle();
      #2;
      checks++; if (dm_rvalid_o !== 1'b0) begin errors++; $display("FAIL rso_dm_rvalid_after2: got %b want 0", dm_rvalid_o); end
      checks++; if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL rso_if_read: got %b/%h want 1/deadbeef", if_rvalid_o, if_rdata_o); end
      @(negedge clk);
   endtask

   task automatic test_random;
      logic        ifr, dmr, dwe, eif, edm, e_pend, e_own_if, last_if_g, last_dm_g;
      logic [15:0] ifa, dma;
      logic [31:0] dwd, e_data;
      int unsigned cnt, wait_cnt, max_wait;
      ifr = 0; dmr = 0; dwe = 0; ifa = '0; dma = '0; dwd = '0;
      e_pend = 0; e_own_if = 0; e_data = '0; last_if_g = 0; last_dm_g = 0;
      cnt = 0; wait_cnt = 0; max_wait = 0;
      for (int n = 0; n < 10000; n++) begin
         @(negedge clk);
         if (ifr && !last_if_g) begin
            if ($urandom_range(0, 15) == 0) ifr = 1'b0;
         end else begin
            ifr = ($urandom_range(0, 9) < 6);
            ifa = 16'h0200 + 16'($urandom_range(0, 15));
         end
         if (dmr && !last_dm_g) begin
            if ($urandom_range(0, 15) == 0) dmr = 1'b0;
         end else begin
            dmr = ($urandom_range(0, 9) < 7);
            dwe = ($urandom_range(0, 1) == 1);
            dma = 16'h0200 + 16'($urandom_range(0, 15));
            dwd = $urandom;
         end
         if_req_i = ifr; if_addr_i = ifa;
         dm_req_i = dmr; dm_we_i = dwe; dm_addr_i = dma; dm_wdata_i = dwd;
         #2;
         eif = ifr && (!dmr || cnt >= STARVE_MAX);
         edm = dmr && !eif;
         checks++; if (if_gnt_o !== eif) begin errors++; $display("FAIL rnd_if_gnt[%0d]: got %b want %b", n, if_gnt_o, eif); end
         checks++; if (dm_gnt_o !== edm) begin errors++; $display("FAIL rnd_dm_gnt[%0d]: got %b want %b", n, dm_gnt_o, edm); end
         checks++; if (mem_w_o !== (edm & dwe)) begin errors++; $display("FAIL rnd_mem_w[%0d]: got %b want %b", n, mem_w_o, edm & dwe); end
         if (eif || edm) begin
            checks++; if (mem_a_o !== (eif ? ifa : dma)) begin errors++; $display("FAIL rnd_mem_a[%0d]: got %h want %h", n, mem_a_o, eif ? ifa : dma); end
         end
         checks++; if (if_rvalid_o !== (e_pend & e_own_if)) begin errors++; $display("FAIL rnd_if_rvalid[%0d]: got %b want %b", n, if_rvalid_o, e_pend & e_own_if); end
         checks++; if (dm_rvalid_o !== (e_pend & !e_own_if)) begin errors++; $display("FAIL rnd_dm_rvalid[%0d]: got %b want %b", n, dm_rvalid_o, e_pend & !e_own_if); end
         if (e_pend) begin
            checks++;
            if ((e_own_if ? if_rdata_o : dm_rdata_o) !== e_data)
               begin errors++; $display("FAIL rnd_rdata[%0d]: got %h want %h", n, e_own_if ? if_rdata_o : dm_rdata_o, e_data); end
         end
         e_pend = (eif || edm) && !(edm && dwe);
         if (eif || edm) begin
            e_own_if = eif;
            e_data   = ref_read(eif ? ifa : dma);
         end
         if (edm && dwe) begin
            ref_mem[dma] = dwd;
            ref_wr[dma]  = 1'b1;
         end
         if (!ifr || eif) cnt = 0;
         else if (edm && cnt < STARVE_MAX) cnt++;
         if (ifr && dmr && !if_gnt_o) wait_cnt++;
         else if (if_gnt_o || !ifr) wait_cnt = 0;
         if (wait_cnt > max_wait) max_wait = wait_cnt;
         last_if_g = if_gnt_o;
         last_dm_g = dm_gnt_o;
      end
      @(negedge clk);
      drive_idle();
      checks++; if (max_wait > STARVE_MAX) begin errors++; $display("FAIL rnd_if_max_wait: got %0d want <= %0d", max_wait, STARVE_MAX); end
   endtask

   initial begin
      drive_idle();
      test_reset();
      test_if_read();
      test_starvation();
      test_write_read();
      test_withdraw();
      test_reset_outstanding();
      test_random();
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
